// File: rtl/modulation_timer.sv
// ---------------------------------------------------------------------------
// modulation_timer
//
// Produces the per-segment modulation sync index
//     sync_idx[i] = floor(sys_time / freq_div[i]) mod (cycle[i] + 1)
// for the modulation swapchain. A single shared restoring divider is
// time-multiplexed round-robin over the segments. Each segment computation
// takes 116 cycles:
//     LATCH (1) -> DIV_Q (57) -> DIV_R (57) -> COMMIT (1)
// A zero divider skips both divisions and commits 0 two cycles after LATCH.
//
// Ports
//   clk             system clock (sys_time advances on it)
//   rst_n           asynchronous active-low reset
//   sys_time        57-bit unsigned system time
//   update_settings one-cycle strobe: load shadows, abort, restart at seg 0
//   cycle[i]        last index of segment i (length = cycle + 1)
//   freq_div[i]     sys_time ticks per index step (0 forces index 0)
//   sync_idx[i]     registered index of segment i
//   idx_valid       one-cycle pulse per committed index
//   idx_seg         segment committed while idx_valid is high
// ---------------------------------------------------------------------------
module modulation_timer #(
    parameter int NumSegment = 2,
    localparam int SegW = (NumSegment > 1) ? $clog2(NumSegment) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [56:0]                  sys_time,
    input  logic                         update_settings,
    input  logic [NumSegment-1:0][15:0]  cycle,
    input  logic [NumSegment-1:0][15:0]  freq_div,
    output logic [NumSegment-1:0][15:0]  sync_idx,
    output logic                         idx_valid,
    output logic [SegW-1:0]              idx_seg
);

    typedef enum logic [1:0] {
        ST_LATCH  = 2'd0,
        ST_DIV_Q  = 2'd1,
        ST_DIV_R  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    localparam logic [5:0] LastBit = 6'd56;

    state_t           state_reg;
    state_t           state_next;
    logic [SegW-1:0]  seg_reg;

    logic [15:0]      cyc_s [NumSegment];
    logic [15:0]      div_s [NumSegment];

    // work_reg holds the dividend being shifted out MSB first; quotient bits
    // shift in at the LSB, so after DIV_Q it holds q, the dividend of DIV_R.
    logic [56:0]      work_reg;
    logic [16:0]      rem_reg;
    logic [15:0]      d_reg;
    logic [16:0]      m_reg;
    logic [5:0]       bit_cnt_reg;
    logic             idx_valid_reg;
    logic [SegW-1:0]  idx_seg_reg;

    logic             latch_en;
    logic             step_en;
    logic             commit_en;
    logic             last_bit;

    logic [17:0]      divisor;
    logic [17:0]      shifted;
    logic             q_bit;
    logic [16:0]      rem_step;

    assign last_bit = (bit_cnt_reg == LastBit);

    // -----------------------------------------------------------------------
    // Per-segment shadow registers and output index registers
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < NumSegment; gi++) begin : g_seg
        logic [15:0] cyc_s_reg;
        logic [15:0] div_s_reg;
        logic [15:0] idx_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cyc_s_reg <= '0;
                div_s_reg <= '0;
                idx_reg   <= '0;
            end else begin
                if (update_settings) begin
                    cyc_s_reg <= cycle[gi];
                    div_s_reg <= freq_div[gi];
                end
                if (commit_en && (seg_reg == SegW'(gi))) begin
                    idx_reg <= rem_reg[15:0];
                end
            end
        end

        assign cyc_s[gi]    = cyc_s_reg;
        assign div_s[gi]    = div_s_reg;
        assign sync_idx[gi] = idx_reg;
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_LATCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic. A settings update aborts from any state.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (update_settings) begin
            state_next = ST_LATCH;
        end else begin
            case (state_reg)
                ST_LATCH:  state_next = (div_s[seg_reg] == 16'd0) ? ST_COMMIT : ST_DIV_Q;
                ST_DIV_Q:  if (last_bit) state_next = ST_DIV_R;
                ST_DIV_R:  if (last_bit) state_next = ST_COMMIT;
                ST_COMMIT: state_next = ST_LATCH;
                default:   state_next = ST_LATCH;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM: outputs. The abort suppresses every action, including a commit.
    // -----------------------------------------------------------------------
    always_comb begin
        latch_en  = 1'b0;
        step_en   = 1'b0;
        commit_en = 1'b0;
        if (!update_settings) begin
            case (state_reg)
                ST_LATCH:           latch_en  = 1'b1;
                ST_DIV_Q, ST_DIV_R: step_en   = 1'b1;
                ST_COMMIT:          commit_en = 1'b1;
                default:            ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Shared restoring divider step. The partial remainder always stays
    // below the divisor (<= 0x10000), so 17 stored bits suffice; the shifted
    // trial value needs 18.
    // -----------------------------------------------------------------------
    always_comb begin
        divisor  = (state_reg == ST_DIV_Q) ? {2'b00, d_reg} : {1'b0, m_reg};
        shifted  = {rem_reg, work_reg[56]};
        q_bit    = (shifted >= divisor);
        rem_step = q_bit ? 17'(shifted - divisor) : shifted[16:0];
    end

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_reg       <= '0;
            work_reg      <= '0;
            rem_reg       <= '0;
            d_reg         <= '0;
            m_reg         <= '0;
            bit_cnt_reg   <= '0;
            idx_valid_reg <= 1'b0;
            idx_seg_reg   <= '0;
        end else begin
            idx_valid_reg <= commit_en;

            if (update_settings) begin
                seg_reg <= '0;
            end

            if (latch_en) begin
                work_reg    <= sys_time;
                d_reg       <= div_s[seg_reg];
                // Extend before adding so 0xFFFF + 1 becomes 0x10000.
                m_reg       <= {1'b0, cyc_s[seg_reg]} + 17'd1;
                // A zero divider commits straight from this cleared value.
                rem_reg     <= '0;
                bit_cnt_reg <= '0;
            end

            if (step_en) begin
                work_reg    <= {work_reg[55:0], q_bit};
                bit_cnt_reg <= last_bit ? 6'd0 : bit_cnt_reg + 6'd1;
                // The first division's remainder is discarded; the second
                // division starts from a clean partial remainder.
                if (last_bit && (state_reg == ST_DIV_Q)) begin
                    rem_reg <= '0;
                end else begin
                    rem_reg <= rem_step;
                end
            end

            if (commit_en) begin
                idx_seg_reg <= seg_reg;
                seg_reg     <= (seg_reg == SegW'(NumSegment - 1)) ? '0 : seg_reg + 1'b1;
            end
        end
    end

    assign idx_valid = idx_valid_reg;
    assign idx_seg   = idx_seg_reg;

endmodule

// File: doc/modulation_timer.md
# modulation_timer

Generates the per-segment modulation sync index SYNC_IDX[i] = floor(SYS_TIME / FREQ_DIV[i]) mod (CYCLE[i] + 1) from the shared 57-bit system time. Sits directly upstream of the modulation swapchain, feeding its SYNC_IDX inputs. The swapchain's CYCLE convention applies: CYCLE holds the last index, one less than the length. A single shared restoring divider is time-multiplexed round-robin over segments, with no hardware multipliers or dividers.

## Interface
- NumSegment, default params::NumSegment (2): number of modulation segments.
- CLK  in  1  system clock; SYS_TIME advances on it.
- RST_N  in  1  asynchronous, active-low reset.
- SYS_TIME  in  57  system time, unsigned.
- UPDATE_SETTINGS  in  1  one-cycle strobe; latch CYCLE/FREQ_DIV into shadow registers.
- CYCLE[NumSegment]  in  16 each  last index per segment; length = CYCLE+1, 1..65536.
- FREQ_DIV[NumSegment]  in  16 each  sys-time ticks per index step; 0 is illegal.
- SYNC_IDX[NumSegment]  out  16 each  current index per segment, registered.
- IDX_VALID  out  1  one-cycle pulse on each SYNC_IDX commit.
- IDX_SEG  out  $clog2(NumSegment) (min 1)  segment committed when IDX_VALID=1.

## Operation
- Shadow registers: cyc_s[i], div_s[i]. They load from CYCLE/FREQ_DIV only on UPDATE_SETTINGS. Reset value is 0.
- States: LATCH, DIV_Q, DIV_R, COMMIT. Segment pointer seg. After reset: state LATCH, seg 0.
- LATCH (1 cycle):
  - Capture t = SYS_TIME, d = div_s[seg] and m = cyc_s[seg] + 1, all for this segment.
  - m is 17 bits and must not wrap: 0xFFFF+1 = 0x10000.
  - If d == 0, go to COMMIT with result 0. Otherwise go to DIV_Q.
- DIV_Q (57 cycles): restoring division t / d, MSB first.
  - One quotient bit per cycle, 17-bit partial remainder.
  - Quotient q is 57 bits. The remainder is discarded.
- DIV_R (57 cycles): restoring division q / m.
  - One bit per cycle, 18-bit partial remainder. The quotient is discarded.
  - The final remainder r < m ≤ 65536, so r fits in 16 bits.
- COMMIT (1 cycle):
  - SYNC_IDX[seg] <= r[15:0]; IDX_VALID <= 1; IDX_SEG <= seg.
  - Wrap seg to 0 after NumSegment-1; otherwise increment. Go to LATCH.
- UPDATE_SETTINGS, in any state:
  - Load the shadows and abort any in-flight computation. Next state is LATCH with seg 0.
  - IDX_VALID is forced to 0 that cycle.
  - All SYNC_IDX outputs hold their old values until each segment recommits.
- UPDATE_SETTINGS coinciding with COMMIT: the abort wins and the commit is dropped.
- Segments never affect each other's outputs. An illegal FREQ_DIV affects only its own segment.

## Timing
- Reset values: SYNC_IDX[*] = 0, IDX_VALID = 0, IDX_SEG = 0, shadows 0, state LATCH, seg 0. Reset is asynchronous; it is released synchronously by the integration.
- Reset mid-operation: all state and outputs return to the reset values immediately.
- Per-segment computation is 116 cycles: LATCH 1 + DIV_Q 57 + DIV_R 57 + COMMIT 1.
  - The first LATCH is the first cycle after RST_N deassertion or after the UPDATE_SETTINGS cycle.
  - SYNC_IDX[0] is updated at the end of cycle 116 (cycle 1 = that first LATCH).
- When d == 0, the computation is 2 cycles: LATCH then COMMIT.
- Refresh period per segment is 116·NumSegment cycles: 232 for 2 segments.
- The index reflects SYS_TIME as sampled at LATCH. Output staleness is bounded by 116·NumSegment cycles.
- Supported operating range: FREQ_DIV ≥ 512. This guarantees at most one index step per refresh period, so the swapchain's change-detect on idx==0 never misses a wrap. Smaller FREQ_DIV values compute correct values but may skip indices.
- IDX_VALID is exactly one cycle wide per commit. It is never asserted in consecutive cycles when NumSegment·116 > 1.

## Test plan
- Reset: hold RST_N=0 with arbitrary inputs -> SYNC_IDX[0]=SYNC_IDX[1]=0 and IDX_VALID=0 throughout. Reassert RST_N mid-DIV_Q -> outputs return to 0 at once.
- Basic: strobe UPDATE_SETTINGS with CYCLE={99,0xFFFF} and FREQ_DIV={10,1}; hold SYS_TIME=12345.
  - SYNC_IDX[0]=34 with IDX_VALID, IDX_SEG=0 at cycle 116.
  - SYNC_IDX[1]=12345 with IDX_SEG=1 at cycle 232.
- Width extremes: CYCLE[0]=0xFFFE, FREQ_DIV[0]=1, SYS_TIME=2^56 -> SYNC_IDX[0]=256. CYCLE[1]=0xFFFF, FREQ_DIV[1]=0xFFFF, SYS_TIME=2^57-1 -> SYNC_IDX[1] matches the reference model (q mod 65536).
- Illegal divider: FREQ_DIV[0]=0 -> SYNC_IDX[0]=0 committed 2 cycles after LATCH; segment 1 computes normally.
- Abort: previous SYNC_IDX[0]=34; new UPDATE_SETTINGS (FREQ_DIV[0]=20, CYCLE[0]=99) at cycle 60 of a computation.
  - SYNC_IDX[0] stays 34 until 116 cycles later, then becomes 17 (SYS_TIME=12345).
  - No IDX_VALID between the strobe and that commit.
- Running time: SYS_TIME increments every CLK from 0, FREQ_DIV=512, CYCLE=3. Each committed SYNC_IDX equals floor(T_latch/512) mod 4, where T_latch is SYS_TIME at that computation's LATCH; successive values never skip an index.
